// File: rtl/md_seq.sv
// Sequencer for the shared FP multiply/divide significand datapath: walks the
// multiplier pass schedule for a multiply or a Newton-Raphson divide.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; in_ready high
// LOOKUP | reciprocal table read, seed loaded into x
// PASS   | one multiplier pass in flight; cnt counts down to the load cycle
// DONE   | completion held until the consumer takes it
module md_seq #(
   parameter int MUL_LAT = 2,
   parameter int NR_ITER = 3,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_fdiv,
   input  logic             in_special,
   input  logic [TAG_W-1:0] in_tag,
   output logic             mul_start,
   output logic [2:0]       mul_sel,
   output logic             lut_en,
   output logic             ld_x,
   output logic             ld_a,
   output logic             ld_q,
   output logic             ld_rem,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_fdiv,
   output logic [TAG_W-1:0] out_tag
);

   localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
   localparam int IT_W  = (NR_ITER < 2) ? 1 : $clog2(NR_ITER);
   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(MUL_LAT);
   localparam logic [IT_W-1:0]  IT_LAST  = IT_W'(NR_ITER - 1);

   typedef enum logic [1:0] {IDLE, LOOKUP, PASS, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         sel_q, sel_d;
   logic [IT_W-1:0]    it_q, it_d;
   logic               fdiv_q, fdiv_d;
   logic [TAG_W-1:0]   tag_q, tag_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         it_q    <= '0;
         fdiv_q  <= 1'b0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         it_q    <= it_d;
         fdiv_q  <= fdiv_d;
         tag_q   <= tag_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      it_d      = it_q;
      fdiv_d    = fdiv_q;
      tag_d     = tag_q;
      in_ready  = 1'b0;
      mul_start = 1'b0;
      mul_sel   = 3'd0;
      lut_en    = 1'b0;
      ld_x      = 1'b0;
      ld_a      = 1'b0;
      ld_q      = 1'b0;
      ld_rem    = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               fdiv_d = in_fdiv;
               tag_d  = in_tag;
               if (in_special) begin
                  state_d = DONE;
               end else if (in_fdiv) begin
                  state_d = LOOKUP;
               end else begin
                  state_d = PASS;
                  sel_d   = 3'd0;
                  cnt_d   = CNT_TOP;
               end
            end
         end
         LOOKUP: begin
            lut_en  = 1'b1;
            ld_x    = 1'b1;
            state_d = PASS;
            sel_d   = 3'd1;
            it_d    = '0;
            cnt_d   = CNT_TOP;
         end
         PASS: begin
            mul_sel   = sel_q;
            mul_start = (cnt_q == CNT_TOP);
            if (cnt_q == '0) begin
               cnt_d = CNT_TOP;
               case (sel_q)
                  3'd0: begin
                     ld_q    = 1'b1;
                     state_d = DONE;
                  end
                  3'd1: begin
                     ld_a  = 1'b1;
                     sel_d = 3'd2;
                  end
                  3'd2: begin
                     ld_x = 1'b1;
                     if (it_q == IT_LAST) begin
                        it_d  = '0;
                        sel_d = 3'd3;
                     end else begin
                        it_d  = it_q + IT_W'(1);
                        sel_d = 3'd1;
                     end
                  end
                  3'd3: begin
                     ld_q  = 1'b1;
                     sel_d = 3'd4;
                  end
                  default: begin
                     ld_rem  = 1'b1;
                     state_d = DONE;
                  end
               endcase
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
      endcase

      // abort gates every strobe in the same cycle it is raised
      if (flush) begin
         state_d   = IDLE;
         cnt_d     = '0;
         sel_d     = '0;
         it_d      = '0;
         fdiv_d    = fdiv_q;
         tag_d     = tag_q;
         in_ready  = 1'b0;
         mul_start = 1'b0;
         mul_sel   = 3'd0;
         lut_en    = 1'b0;
         ld_x      = 1'b0;
         ld_a      = 1'b0;
         ld_q      = 1'b0;
         ld_rem    = 1'b0;
         out_valid = 1'b0;
      end
   end

   assign busy     = (state_q != IDLE);
   assign out_fdiv = fdiv_q;
   assign out_tag  = tag_q;

endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq with MUL_LAT=2, NR_ITER=3; cycle 0 is the accept cycle.
module tb_md_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       in_fdiv = 1'b0;
   logic       in_special = 1'b0;
   logic [3:0] in_tag = 4'd0;
   logic       mul_start;
   logic [2:0] mul_sel;
   logic       lut_en, ld_x, ld_a, ld_q, ld_rem;
   logic       busy, out_valid;
   logic       out_ready = 1'b1;
   logic       out_fdiv;
   logic [3:0] out_tag;

   int n_tests = 0;
   int n_fail  = 0;

   md_seq #(.MUL_LAT(2), .NR_ITER(3), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_fdiv(in_fdiv),
      .in_special(in_special), .in_tag(in_tag),
      .mul_start(mul_start), .mul_sel(mul_sel), .lut_en(lut_en),
      .ld_x(ld_x), .ld_a(ld_a), .ld_q(ld_q), .ld_rem(ld_rem),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_fdiv(out_fdiv), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   // {mul_start, lut_en, ld_x, ld_a, ld_q, ld_rem, out_valid, in_ready, busy, mul_sel}
   function automatic logic [11:0] obs();
      return {mul_start, lut_en, ld_x, ld_a, ld_q, ld_rem, out_valid, in_ready, busy, mul_sel};
   endfunction

   function automatic logic [11:0] vec(bit ms, bit lu, bit lx, bit la, bit lq, bit lr,
                                       bit ov, bit ir, bit bz, logic [2:0] s);
      return {ms, lu, lx, la, lq, lr, ov, ir, bz, s};
   endfunction

   // drive a request during cycle 0; the following loop starts at the accept edge
   task automatic issue(input bit fdiv, input bit special, input logic [3:0] tag);
      @(negedge clk);
      in_valid = 1'b1; in_fdiv = fdiv; in_special = special; in_tag = tag;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if (obs() !== vec(0,0,0,0,0,0,0,1,0,3'd0)) begin
         n_fail++; $display("FAIL reset_outputs: got %b want %b", obs(), vec(0,0,0,0,0,0,0,1,0,3'd0));
      end
      n_tests++;
      if ({out_fdiv, out_tag} !== 5'b0) begin
         n_fail++; $display("FAIL reset_tag: got %b want 00000", {out_fdiv, out_tag});
      end
   endtask

   task automatic test_mul(input logic [3:0] tag);
      logic [11:0] e;
      issue(1'b0, 1'b0, tag);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1 in_valid = 1'b0;
         @(negedge clk);
         e = vec(c == 1, 0, 0, 0, c == 3, 0, c == 4, c == 5, c <= 4, 3'd0);
         n_tests++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL mul_cycle%0d: got %b want %b", c, obs(), e);
         end
         if (c == 4) begin
            n_tests++;
            if ({out_fdiv, out_tag} !== {1'b0, tag}) begin
               n_fail++; $display("FAIL mul_tag: got %b want %b", {out_fdiv, out_tag}, {1'b0, tag});
            end
         end
      end
   endtask

   task automatic test_div(input logic [3:0] tag);
      logic [11:0] e;
      logic [2:0]  seq [8];
      int          p, ph, starts;
      logic [2:0]  s;
      seq = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4};
      starts = 0;
      issue(1'b1, 1'b0, tag);
      for (int c = 1; c <= 27; c++) begin
         @(posedge clk); #1 in_valid = 1'b0;
         @(negedge clk);
         if (mul_start === 1'b1) starts++;
         if (c == 1) e = vec(0,1,1,0,0,0,0,0,1,3'd0);
         else if (c <= 25) begin
            p = (c - 2) / 3; ph = (c - 2) % 3; s = seq[p];
            e = vec(ph == 0, 0, ph == 2 && s == 3'd2, ph == 2 && s == 3'd1,
                    ph == 2 && s == 3'd3, ph == 2 && s == 3'd4, 0, 0, 1, s);
         end
         else if (c == 26) e = vec(0,0,0,0,0,0,1,0,1,3'd0);
         else e = vec(0,0,0,0,0,0,0,1,0,3'd0);
         n_tests++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL div_cycle%0d: got %b want %b", c, obs(), e);
         end
         if (c == 26) begin
            n_tests++;
            if ({out_fdiv, out_tag} !== {1'b1, tag}) begin
               n_fail++; $display("FAIL div_tag: got %b want %b", {out_fdiv, out_tag}, {1'b1, tag});
            end
         end
      end
      n_tests++;
      if (starts != 8) begin
         n_fail++; $display("FAIL div_start_count: got %0d want 8", starts);
      end
   endtask

   task automatic test_special();
      logic [11:0] e;
      int strobes;
      strobes = 0;
      issue(1'b1, 1'b1, 4'h9);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1 in_valid = 1'b0; in_special = 1'b0;
         @(negedge clk);
         if (mul_start === 1'b1 || lut_en === 1'b1) strobes++;
         e = (c == 1) ? vec(0,0,0,0,0,0,1,0,1,3'd0) : vec(0,0,0,0,0,0,0,1,0,3'd0);
         n_tests++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL special_cycle%0d: got %b want %b", c, obs(), e);
         end
         if (c == 1) begin
            n_tests++;
            if ({out_fdiv, out_tag} !== 5'b11001) begin
               n_fail++; $display("FAIL special_tag: got %b want 11001", {out_fdiv, out_tag});
            end
         end
      end
      n_tests++;
      if (strobes != 0) begin
         n_fail++; $display("FAIL special_no_pass: got %0d strobes want 0", strobes);
      end
   endtask

   task automatic test_backpressure();
      logic [11:0] e;
      out_ready = 1'b0;
      issue(1'b0, 1'b0, 4'hA);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1 in_valid = 1'b0;
         if (c == 9) out_ready = 1'b1;
         @(negedge clk);
         if (c >= 4 && c <= 9) e = vec(0,0,0,0,0,0,1,0,1,3'd0);
         else if (c == 10) e = vec(0,0,0,0,0,0,0,1,0,3'd0);
         else e = vec(c == 1, 0, 0, 0, c == 3, 0, 0, 0, 1, 3'd0);
         n_tests++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL bp_cycle%0d: got %b want %b", c, obs(), e);
         end
         if (c >= 4 && c <= 9) begin
            n_tests++;
            if ({out_fdiv, out_tag} !== 5'b01010) begin
               n_fail++; $display("FAIL bp_tag_cycle%0d: got %b want 01010", c, {out_fdiv, out_tag});
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] e;
      issue(1'b0, 1'b0, 4'h3);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1 in_valid = 1'b0;
         if (c == 5) begin in_valid = 1'b1; in_tag = 4'h7; end
         @(negedge clk);
         e = vec(c == 1 || c == 6, 0, 0, 0, c == 3 || c == 8, 0, c == 4 || c == 9,
                 c == 5 || c == 10, c != 5 && c != 10, 3'd0);
         n_tests++;
         if (obs() !== e) begin
            n_fail++; $display("FAIL b2b_cycle%0d: got %b want %b", c, obs(), e);
         end
         if (c == 4 || c == 9) begin
            n_tests++;
            if (out_tag !== ((c == 4) ? 4'h3 : 4'h7)) begin
               n_fail++; $display("FAIL b2b_tag_cycle%0d: got %h want %h", c, out_tag, (c == 4) ? 4'h3 : 4'h7);
            end
         end
      end
   endtask

   task automatic test_flush();
      issue(1'b1, 1'b0, 4'h5);
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #1 in_valid = 1'b0;
         flush = (c == 10);
         @(negedge clk);
         if (c == 10) begin
            n_tests++;
            if (obs() !== vec(0,0,0,0,0,0,0,0,1,3'd0)) begin
               n_fail++; $display("FAIL flush_gate: got %b want %b", obs(), vec(0,0,0,0,0,0,0,0,1,3'd0));
            end
         end
         if (c == 11) begin
            n_tests++;
            if (obs() !== vec(0,0,0,0,0,0,0,1,0,3'd0)) begin
               n_fail++; $display("FAIL flush_idle: got %b want %b", obs(), vec(0,0,0,0,0,0,0,1,0,3'd0));
            end
         end
      end
      flush = 1'b0;
      test_mul(4'h6);
   endtask

   task automatic test_reset_mid();
      issue(1'b1, 1'b0, 4'hE);
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1 in_valid = 1'b0;
         if (c == 7) rst_n = 1'b0;
      end
      #1;
      n_tests++;
      if (obs() !== vec(0,0,0,0,0,0,0,1,0,3'd0)) begin
         n_fail++; $display("FAIL rst_async: got %b want %b", obs(), vec(0,0,0,0,0,0,0,1,0,3'd0));
      end
      n_tests++;
      if ({out_fdiv, out_tag} !== 5'b0) begin
         n_fail++; $display("FAIL rst_async_tag: got %b want 00000", {out_fdiv, out_tag});
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (obs() !== vec(0,0,0,0,0,0,0,1,0,3'd0)) begin
         n_fail++; $display("FAIL rst_hold: got %b want %b", obs(), vec(0,0,0,0,0,0,0,1,0,3'd0));
      end
      rst_n = 1'b1;
      test_div(4'hC);
   endtask

   initial begin
      #12 rst_n = 1'b1;
      test_reset();
      test_mul(4'h5);
      test_div(4'h2);
      test_special();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
